// File: rtl/obf_key_ctrl.sv
// Key-loading and start-gating controller for an obfuscated (locked) core.
// Loads a working key in fixed-width chunks and only forwards host starts once a key is committed.
module obf_key_ctrl #(
    parameter int KEY_W   = 1535,
    parameter int CHUNK_W = 32
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [CHUNK_W-1:0] key_data,
    input  logic               key_valid,
    input  logic               key_last,
    output logic               key_ready,
    input  logic               key_clear,
    output logic               key_loaded,
    output logic               key_err,
    output logic [KEY_W-1:0]   working_key,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               ap_idle,
    output logic               ap_ready,
    output logic               core_start,
    input  logic               core_done,
    input  logic               core_idle,
    input  logic               core_ready
);

    localparam int NCHUNK = (KEY_W + CHUNK_W - 1) / CHUNK_W;
    localparam int PAD_W  = NCHUNK * CHUNK_W;
    localparam int CNT_W  = $clog2(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [KEY_W-1:0]   shadow_r;
    logic [KEY_W-1:0]   working_key_r;
    logic               key_loaded_r;
    logic               key_err_r;

    logic               key_ready_s;
    logic               accept_s;
    logic               last_idx_s;
    logic               frame_err_s;
    logic               clear_s;
    logic [KEY_W-1:0]   merged_s;

    // Drops a chunk into its slot; bits past the key width fall off the top of the padded vector.
    function automatic logic [KEY_W-1:0] merge_chunk(
        input logic [KEY_W-1:0]   base,
        input logic [CNT_W-1:0]   idx,
        input logic [CHUNK_W-1:0] chunk
    );
        logic [PAD_W-1:0] pad;
        pad = '0;
        pad[KEY_W-1:0] = base;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == CNT_W'(i)) begin
                pad[i*CHUNK_W +: CHUNK_W] = chunk;
            end else begin
                pad[i*CHUNK_W +: CHUNK_W] = pad[i*CHUNK_W +: CHUNK_W];
            end
        end
        return pad[KEY_W-1:0];
    endfunction

    // Handshake, framing and merge decode for the current chunk.
    always_comb begin
        key_ready_s = 1'b0;
        if (!ap_rst_n || key_clear) begin
            key_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: key_ready_s = 1'b1;
                ST_LOAD:  key_ready_s = 1'b1;
                ST_ARMED: key_ready_s = ~ap_start;
                ST_RUN:   key_ready_s = 1'b0;
                default:  key_ready_s = 1'b0;
            endcase
        end
        accept_s    = key_valid & key_ready_s;
        last_idx_s  = (cnt_r == LAST_IDX);
        // A chunk is well framed only when key_last coincides with the final index.
        frame_err_s = key_last ^ last_idx_s;
        clear_s     = key_clear & (state_r != ST_RUN);
        merged_s    = merge_chunk(shadow_r, cnt_r, key_data);
    end

    // Host/core pass-through; starts reach the core only with a committed key.
    always_comb begin
        key_ready   = key_ready_s;
        key_loaded  = key_loaded_r;
        key_err     = key_err_r;
        working_key = working_key_r;
        core_start  = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        if ((state_r == ST_ARMED) || (state_r == ST_RUN)) begin
            core_start = ap_start;
        end else begin
            core_start = 1'b0;
        end
        if (state_r == ST_RUN) begin
            ap_done  = core_done;
            ap_ready = core_ready;
        end else begin
            ap_done  = 1'b0;
            ap_ready = 1'b0;
        end
        if (key_loaded_r) begin
            ap_idle = core_idle;
        end else begin
            ap_idle = 1'b1;
        end
    end

    // Load/run state machine with shadow buffering and atomic key commit.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r       <= ST_EMPTY;
            cnt_r         <= '0;
            shadow_r      <= '0;
            working_key_r <= '0;
            key_loaded_r  <= 1'b0;
            key_err_r     <= 1'b0;
        end else if (clear_s) begin
            state_r       <= ST_EMPTY;
            cnt_r         <= '0;
            shadow_r      <= '0;
            working_key_r <= '0;
            key_loaded_r  <= 1'b0;
            key_err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (core_done) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_EMPTY, ST_LOAD, ST_ARMED: begin
                    if (accept_s) begin
                        if (frame_err_s) begin
                            key_err_r <= 1'b1;
                            shadow_r  <= '0;
                            cnt_r     <= '0;
                            state_r   <= key_loaded_r ? ST_ARMED : ST_EMPTY;
                        end else if (last_idx_s) begin
                            // Shadow is wiped after commit so no partial key lingers.
                            working_key_r <= merged_s;
                            shadow_r      <= '0;
                            key_loaded_r  <= 1'b1;
                            key_err_r     <= 1'b0;
                            cnt_r         <= '0;
                            state_r       <= ST_ARMED;
                        end else begin
                            shadow_r <= merged_s;
                            cnt_r    <= cnt_r + CNT_W'(1);
                            state_r  <= ST_LOAD;
                        end
                    end else if ((state_r == ST_ARMED) && ap_start) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obf_key_ctrl.sv
// Directed bench for obf_key_ctrl with KEY_W=70, CHUNK_W=32 (three chunks per key).
module tb_obf_key_ctrl;

    localparam int KEY_W   = 70;
    localparam int CHUNK_W = 32;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic [CHUNK_W-1:0] key_data;
    logic               key_valid;
    logic               key_last;
    logic               key_ready;
    logic               key_clear;
    logic               key_loaded;
    logic               key_err;
    logic [KEY_W-1:0]   working_key;
    logic               ap_start;
    logic               ap_done;
    logic               ap_idle;
    logic               ap_ready;
    logic               core_start;
    logic               core_done;
    logic               core_idle;
    logic               core_ready;

    int n_chk  = 0;
    int n_fail = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic [KEY_W-1:0] k1;
    logic [KEY_W-1:0] k2;
    logic [KEY_W-1:0] k3;

    obf_key_ctrl #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W)) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .key_last    (key_last),
        .key_ready   (key_ready),
        .key_clear   (key_clear),
        .key_loaded  (key_loaded),
        .key_err     (key_err),
        .working_key (working_key),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_idle   (core_idle),
        .core_ready  (core_ready)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic logic [KEY_W-1:0] build_key(input logic [31:0] c0, input logic [31:0] c1,
                                                   input logic [31:0] c2);
        logic [95:0] full;
        full = {c2, c1, c0};
        return full[KEY_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [KEY_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, working_key, e);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        key_data  = d;
        key_valid = 1'b1;
        key_last  = l;
        #1;
        chk("key_ready_load", key_ready, 1'b1);
        tick();
        key_valid = 1'b0;
        key_last  = 1'b0;
        key_data  = 32'h0;
        #1;
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        key_data   = 32'h0;
        key_valid  = 1'b1;
        key_last   = 1'b0;
        key_clear  = 1'b0;
        ap_start   = 1'b1;
        core_done  = 1'b1;
        core_idle  = 1'b0;
        core_ready = 1'b1;
        #2;
        chk("rst_key_ready", key_ready, 1'b0);
        chk("rst_key_loaded", key_loaded, 1'b0);
        chk("rst_key_err", key_err, 1'b0);
        chk("rst_working_key", working_key, '0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_ap_done", ap_done, 1'b0);
        chk("rst_ap_ready", ap_ready, 1'b0);
        chk("rst_ap_idle", ap_idle, 1'b1);
        repeat (2) @(posedge ap_clk);
        #1;
        key_valid = 1'b0;
        ap_rst_n  = 1'b1;
        #1;

        // Start before any key is loaded must never reach the core.
        for (int i = 0; i < 3; i++) begin
            chk("nokey_core_start", core_start, 1'b0);
            chk("nokey_ap_idle", ap_idle, 1'b1);
            chk("nokey_ap_done", ap_done, 1'b0);
            tick();
        end
        ap_start  = 1'b0;
        core_done = 1'b0;
        chk("nokey_key_err", key_err, 1'b0);

        // First key load; working key must not move until the last chunk.
        k1 = build_key(32'h11111111, 32'h22222222, 32'h0000003F);
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        chk("midload_loaded", key_loaded, 1'b0);
        chk("midload_key", working_key, '0);
        exp_q.push_back(k1);
        send(32'h0000003F, 1'b1);
        chk("load1_loaded", key_loaded, 1'b1);
        chk("load1_err", key_err, 1'b0);
        pop_chk("load1_key");
        chk("load1_key_const", working_key, 70'h3F_2222222211111111);
        chk("armed_ap_idle", ap_idle, 1'b0);
        chk("armed_ready", key_ready, 1'b1);

        // Start and chunk together in ARMED: start wins.
        ap_start  = 1'b1;
        key_valid = 1'b1;
        key_data  = 32'hDEADBEEF;
        #1;
        chk("armed_start_core_start", core_start, 1'b1);
        chk("armed_start_key_ready", key_ready, 1'b0);
        tick();
        key_valid = 1'b0;
        #1;
        chk("run_key_ready", key_ready, 1'b0);
        chk("run_core_start", core_start, 1'b1);
        chk("run_ap_ready", ap_ready, 1'b1);
        chk("run_ap_done", ap_done, 1'b0);
        key_clear = 1'b1;
        #1;
        chk("run_clear_ready", key_ready, 1'b0);
        tick();
        key_clear = 1'b0;
        chk("run_clear_key", working_key, k1);
        chk("run_clear_loaded", key_loaded, 1'b1);
        repeat (3) tick();
        core_done = 1'b1;
        #1;
        chk("run_done_pulse", ap_done, 1'b1);
        tick();
        core_done = 1'b0;
        ap_start  = 1'b0;
        #1;
        chk("after_done_ap_done", ap_done, 1'b0);
        chk("after_done_ap_ready", ap_ready, 1'b0);
        chk("after_done_key_ready", key_ready, 1'b1);
        chk("after_done_core_start", core_start, 1'b0);
        core_done = 1'b1;
        #1;
        chk("armed_done_masked", ap_done, 1'b0);
        core_done = 1'b0;

        // Framing error on chunk index 1 during a reload.
        send(32'hCAFEF00D, 1'b0);
        ap_start = 1'b1;
        #1;
        chk("reload_core_start", core_start, 1'b0);
        ap_start = 1'b0;
        exp_q.push_back(k1);
        send(32'h12345678, 1'b1);
        chk("ferr_key_err", key_err, 1'b1);
        chk("ferr_loaded", key_loaded, 1'b1);
        pop_chk("ferr_key_kept");
        k2 = build_key(32'hAAAA5555, 32'h0F0F0F0F, 32'hFFFFFFFF);
        send(32'hAAAA5555, 1'b0);
        send(32'h0F0F0F0F, 1'b0);
        chk("reload_mid_err", key_err, 1'b1);
        chk("reload_mid_key", working_key, k1);
        exp_q.push_back(k2);
        send(32'hFFFFFFFF, 1'b1);
        chk("reload_err_cleared", key_err, 1'b0);
        pop_chk("reload_key");
        chk("reload_key_const", working_key, 70'h3F_0F0F0F0FAAAA5555);

        // Reset asserted with cnt=2 discards everything.
        send(32'h55555555, 1'b0);
        send(32'h66666666, 1'b0);
        ap_start = 1'b1;
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_key", working_key, '0);
        chk("mid_rst_loaded", key_loaded, 1'b0);
        chk("mid_rst_key_ready", key_ready, 1'b0);
        chk("mid_rst_core_start", core_start, 1'b0);
        chk("mid_rst_ap_idle", ap_idle, 1'b1);
        tick();
        ap_rst_n = 1'b1;
        ap_start = 1'b0;
        #1;
        k3 = build_key(32'h01234567, 32'h89ABCDEF, 32'h00000015);
        send(32'h01234567, 1'b0);
        send(32'h89ABCDEF, 1'b0);
        exp_q.push_back(k3);
        send(32'h00000015, 1'b1);
        chk("post_rst_loaded", key_loaded, 1'b1);
        pop_chk("post_rst_key");

        // Clear in ARMED with a chunk offered.
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_data  = 32'h77777777;
        #1;
        chk("clear_key_ready", key_ready, 1'b0);
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        #1;
        chk("clear_key", working_key, '0);
        chk("clear_loaded", key_loaded, 1'b0);
        chk("clear_err", key_err, 1'b0);
        chk("clear_ap_idle", ap_idle, 1'b1);
        ap_start = 1'b1;
        #1;
        chk("clear_core_start", core_start, 1'b0);
        tick();
        chk("clear_core_start2", core_start, 1'b0);
        ap_start = 1'b0;

        // Framing error with no key committed stays in EMPTY.
        send(32'h99999999, 1'b0);
        exp_q.push_back('0);
        send(32'h88888888, 1'b1);
        chk("empty_ferr_err", key_err, 1'b1);
        chk("empty_ferr_loaded", key_loaded, 1'b0);
        pop_chk("empty_ferr_key");
        ap_start = 1'b1;
        #1;
        chk("empty_ferr_core_start", core_start, 1'b0);
        ap_start = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/obf_key_ctrl.md
OBF_KEY_CTRL -- requirements
Module: obf_key_ctrl

Interface
REQ-001 SHALL have parameter KEY_W, default 1535, working-key width in bits (KEY_W >= 2).
REQ-002 SHALL have parameter CHUNK_W, default 32, key-load chunk width; NCHUNK = ceil(KEY_W/CHUNK_W), NCHUNK >= 2.
REQ-003 SHALL have ports:
  ap_clk  in  1  single clock; all state on rising edge
  ap_rst_n  in  1  asynchronous active-low reset
  key_data  in  CHUNK_W  key chunk
  key_valid  in  1  chunk valid
  key_last  in  1  marks final chunk
  key_ready  out  1  chunk accept
  key_clear  in  1  zeroize request
  key_loaded  out  1  committed key present
  key_err  out  1  sticky framing error
  working_key  out  KEY_W  committed key to locked core
  ap_start  in  1  host start
  ap_done  out  1  host done
  ap_idle  out  1  host idle
  ap_ready  out  1  host ready
  core_start  out  1  start to locked core
  core_done  in  1  core done
  core_idle  in  1  core idle
  core_ready  in  1  core ready

Function
REQ-004 SHALL implement states EMPTY, LOAD, ARMED, RUN, plus chunk counter cnt (0..NCHUNK-1) and KEY_W-bit shadow register.
REQ-005 SHALL accept a chunk when key_valid & key_ready; chunk index cnt writes bits [cnt*CHUNK_W +: CHUNK_W] of shadow; final-chunk bits beyond KEY_W-1 are discarded.
REQ-006 SHALL drive key_ready = 1 in EMPTY and LOAD, and in ARMED when ap_start=0; key_ready = 0 in RUN and whenever key_clear=1.
REQ-007 EMPTY/ARMED: accepted chunk -> LOAD, cnt=1; chunk stored at index 0.
REQ-008 LOAD: accepted chunk at cnt<NCHUNK-1 with key_last=0 -> stored, cnt+1.
REQ-009 LOAD: accepted chunk at cnt=NCHUNK-1 with key_last=1 -> commit: working_key takes shadow merged with this chunk on the same edge, key_loaded=1, key_err=0, cnt=0, -> ARMED.
REQ-010 Framing error (key_last=1 at cnt<NCHUNK-1, or key_last=0 at cnt=NCHUNK-1) SHALL set key_err, clear shadow and cnt, leave working_key/key_loaded unchanged, -> ARMED if key_loaded else EMPTY.
REQ-011 working_key SHALL change only on commit, key_clear, or reset; never mid-load.
REQ-012 ARMED: core_start = ap_start; ap_start=1 -> RUN next edge.
REQ-013 RUN: core_start = ap_start; core_done=1 -> ARMED next edge (re-enters RUN next cycle if ap_start still 1).
REQ-014 ap_done = core_done and ap_ready = core_ready when state is RUN, else 0; ap_idle = core_idle when key_loaded=1, else 1.
REQ-015 EMPTY/LOAD with key_loaded=0: core_start=0, ap_start ignored, no error.
REQ-016 LOAD with key_loaded=1 (reload): core_start=0; ap_start held until return to ARMED.
REQ-017 key_clear=1 outside RUN SHALL zero working_key, shadow, cnt, key_loaded, key_err, -> EMPTY; in RUN key_clear is ignored.
REQ-018 Simultaneous ap_start=1 and key_valid=1 in ARMED: start wins, chunk not accepted.

Reset
REQ-019 ap_rst_n=0 SHALL asynchronously set state EMPTY, cnt=0, shadow=0, working_key=0, key_loaded=0, key_err=0, key_ready=0 during reset, core_start=0, ap_done=0, ap_ready=0, ap_idle=1.
REQ-020 Reset mid-load or mid-run SHALL discard all progress; first chunk after release is index 0.

Verification (KEY_W=70, CHUNK_W=32, NCHUNK=3)
REQ-021 Chunks 0x11111111, 0x22222222, 0x0000003F(last) -> key_loaded=1 after third edge, working_key=0x3F_2222222211111111, state ARMED.
REQ-022 ap_start=1 before any load -> core_start=0, ap_idle=1, ap_done=0 throughout.
REQ-023 Loaded key, ap_start=1, core_done pulsed after 5 cycles -> core_start follows ap_start, ap_done=1 one cycle, key_ready=0 during RUN.
REQ-024 key_last=1 on chunk 1 -> key_err=1, working_key unchanged, next chunk taken as index 0; subsequent good load clears key_err.
REQ-025 key_clear=1 in ARMED with key_valid=1 -> chunk rejected, working_key=0, key_loaded=0, EMPTY; key_clear during RUN -> no effect.
REQ-026 ap_rst_n low during cnt=2 -> all outputs at reset values; fresh 3-chunk load commits correctly.
